// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage divider issue controller: divider handshake
// levels, register widths and the controller state encoding.
package div_issue_ctrl_pkg;

  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;

  localparam int REG_W        = 32;
  localparam int REG_DOUBLE_W = 64;

  // Controller states, kept distinct from the divider's own state names.
  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_BUSY = 2'd1,
    CTRL_DONE = 2'd2,
    CTRL_GAP  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: latches operands, drives start/annul,
// stalls the pipeline while busy and hands HI/LO to the HI/LO write path.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int ANNUL_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_req_i,
  input  logic                    signed_i,
  input  logic [REG_W-1:0]        opdata1_i,
  input  logic [REG_W-1:0]        opdata2_i,
  input  logic                    flush_i,
  input  logic [REG_DOUBLE_W-1:0] div_result_i,
  input  logic                    div_ready_i,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [REG_W-1:0]        div_opdata1_o,
  output logic [REG_W-1:0]        div_opdata2_o,
  output logic                    stallreq_o,
  output logic                    whilo_o,
  output logic [REG_W-1:0]        hi_o,
  output logic [REG_W-1:0]        lo_o,
  output logic                    err_o
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(ANNUL_GAP + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ANNUL_GAP - 1);

  ctrl_state_e      state_r, state_nxt_s;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic             start_r, start_nxt_s;
  logic             annul_r, annul_nxt_s;
  logic             whilo_r, whilo_nxt_s;
  logic             err_r, err_nxt_s;
  logic             signed_r;
  logic [REG_W-1:0] op1_r, op2_r, hi_r, lo_r;
  logic             latch_s, capture_s, stall_s, issue_req_s;

  assign issue_req_s = div_req_i & ~flush_i;

  // Next-state, handshake and stall decode; flush outranks ready, ready outranks timeout.
  always_comb begin
    state_nxt_s   = state_r;
    to_cnt_nxt_s  = to_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    start_nxt_s   = start_r;
    annul_nxt_s   = 1'b0;
    whilo_nxt_s   = 1'b0;
    err_nxt_s     = 1'b0;
    latch_s       = 1'b0;
    capture_s     = 1'b0;
    stall_s       = 1'b0;
    case (state_r)
      CTRL_IDLE: begin
        stall_s     = issue_req_s;
        start_nxt_s = DIV_STOP;
        if (issue_req_s) begin
          latch_s      = 1'b1;
          start_nxt_s  = DIV_START;
          to_cnt_nxt_s = '0;
          state_nxt_s  = CTRL_BUSY;
        end else begin
          state_nxt_s = CTRL_IDLE;
        end
      end
      CTRL_BUSY: begin
        stall_s     = 1'b1;
        start_nxt_s = DIV_START;
        if (flush_i) begin
          annul_nxt_s   = 1'b1;
          start_nxt_s   = DIV_STOP;
          gap_cnt_nxt_s = '0;
          state_nxt_s   = CTRL_GAP;
        end else if (div_ready_i == DIV_RESULT_READY) begin
          capture_s   = 1'b1;
          state_nxt_s = CTRL_DONE;
        end else if (to_cnt_r == TO_LAST) begin
          annul_nxt_s   = 1'b1;
          err_nxt_s     = 1'b1;
          start_nxt_s   = DIV_STOP;
          gap_cnt_nxt_s = '0;
          state_nxt_s   = CTRL_GAP;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end
      end
      CTRL_DONE: begin
        // Dropping start here lets the divider leave its end state.
        start_nxt_s = DIV_STOP;
        whilo_nxt_s = ~flush_i;
        state_nxt_s = CTRL_IDLE;
      end
      CTRL_GAP: begin
        stall_s     = issue_req_s;
        start_nxt_s = DIV_STOP;
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = CTRL_IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        start_nxt_s = DIV_STOP;
        state_nxt_s = CTRL_IDLE;
      end
    endcase
  end

  // Control state, counters and one-cycle pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= CTRL_IDLE;
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
      start_r   <= 1'b0;
      annul_r   <= 1'b0;
      whilo_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      to_cnt_r  <= to_cnt_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      start_r   <= start_nxt_s;
      annul_r   <= annul_nxt_s;
      whilo_r   <= whilo_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  // Operand latch on issue and HI/LO capture on result; both hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signed_r <= 1'b0;
      op1_r    <= '0;
      op2_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      if (latch_s) begin
        signed_r <= signed_i;
        op1_r    <= opdata1_i;
        op2_r    <= opdata2_i;
      end
      if (capture_s) begin
        hi_r <= div_result_i[REG_DOUBLE_W-1:REG_W];
        lo_r <= div_result_i[REG_W-1:0];
      end
    end
  end

  assign div_start_o   = start_r;
  assign div_annul_o   = annul_r;
  assign div_signed_o  = signed_r;
  assign div_opdata1_o = op1_r;
  assign div_opdata2_o = op2_r;
  assign stallreq_o    = stall_s;
  assign whilo_o       = whilo_r;
  assign hi_o          = hi_r;
  assign lo_o          = lo_r;
  assign err_o         = err_r;

endmodule
